// File: rtl/vid_pkg.sv
// Shared types and constants for the video frame checker.
// Optional CRC comparison is enabled by VID_FRAME_CHECKER_CRC_CMP_EN (see vid_frame_checker.sv).
package vid_pkg;

  localparam int          H_ACTIVE_DEF = 640;
  localparam int          V_ACTIVE_DEF = 480;
  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vid_frame_checker_if.sv
// Pixel stream bundle (data enable, vsync, 3:3:3 RGB) seen by the frame checker.
interface vid_frame_checker_if;

  logic       de;
  logic       vs_n;
  logic [2:0] rgb_r;
  logic [2:0] rgb_g;
  logic [2:0] rgb_b;

  modport master (output de, vs_n, rgb_r, rgb_g, rgb_b);
  modport slave  (input  de, vs_n, rgb_r, rgb_g, rgb_b);

endinterface

// File: rtl/crc16_sym9.sv
// Combinational CRC-16 (poly 0x1021, no reflection) advanced by one 9-bit symbol, MSB first.
module crc16_sym9
  import vid_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [8:0]  sym,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int unsigned i = 0; i < 9; i++) begin
      if (c[15] ^ sym[4'(8 - i)]) begin
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/vid_frame_checker.sv
// Per-frame line length / line count / CRC-16 checker for a DE + vsync pixel stream.
// Define VID_FRAME_CHECKER_CRC_CMP_EN to add exp_crc / crc_mismatch and fold CRC into frame_ok.
module vid_frame_checker
  import vid_pkg::*;
#(
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [15:0] CRC_INIT = CRC16_INIT
) (
  input  logic                clk_pix,
  input  logic                resetn,
  vid_frame_checker_if.slave  vid,
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
  input  logic [15:0]         exp_crc,
  output logic                crc_mismatch,
`endif
  output logic                frame_done,
  output logic [15:0]         frame_crc,
  output logic                frame_ok,
  output logic                err_hlen,
  output logic                err_vlen,
  output logic [15:0]         frame_cnt
);

  localparam logic [9:0] H_LEN = 10'(H_ACTIVE);
  localparam logic [9:0] V_LEN = 10'(V_ACTIVE);

  state_t      state;
  logic        vs_q;
  logic        de_q;
  logic [9:0]  pix_cnt;
  logic [9:0]  line_cnt;
  logic [15:0] crc;
  logic        err_hlen_acc;

  rgb333_t     pix;
  logic [15:0] crc_step;
  logic        vs_edge;
  logic        line_end;
  logic        close_line;
  logic        hlen_bad;
  logic        vlen_bad;
  logic        crc_bad;
  logic [9:0]  pix_fin;
  logic [9:0]  line_fin;
  logic [15:0] crc_fin;

  assign pix = {vid.rgb_r, vid.rgb_g, vid.rgb_b};

  crc16_sym9 u_crc (
    .crc_in  (crc),
    .sym     (pix),
    .crc_out (crc_step)
  );

  // The *_fin values fold in the current cycle so a pixel or open line
  // coincident with the vsync edge belongs to the frame being closed.
  always_comb begin
    vs_edge    = vs_q & ~vid.vs_n;
    line_end   = de_q & ~vid.de;
    pix_fin    = vid.de ? sat_inc10(pix_cnt) : pix_cnt;
    crc_fin    = vid.de ? crc_step : crc;
    close_line = vs_edge ? (de_q | vid.de) : line_end;
    line_fin   = close_line ? sat_inc10(line_cnt) : line_cnt;
    hlen_bad   = close_line & (pix_fin != H_LEN);
    vlen_bad   = (line_fin != V_LEN);
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
    crc_bad    = (crc_fin != exp_crc);
`else
    crc_bad    = 1'b0;
`endif
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      vs_q         <= 1'b1;
      de_q         <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      crc          <= CRC_INIT;
      err_hlen_acc <= 1'b0;
      frame_done   <= 1'b0;
      frame_crc    <= '0;
      frame_ok     <= 1'b0;
      err_hlen     <= 1'b0;
      err_vlen     <= 1'b0;
      frame_cnt    <= '0;
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
      crc_mismatch <= 1'b0;
`endif
    end else begin
      vs_q       <= vid.vs_n;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          de_q <= 1'b0;
          if (vs_edge) begin
            state        <= FRAME;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            crc          <= CRC_INIT;
            err_hlen_acc <= 1'b0;
          end
        end
        FRAME: begin
          if (vs_edge) begin
            // de_q is cleared so the line closed here is not counted again next cycle.
            de_q         <= 1'b0;
            frame_done   <= 1'b1;
            frame_crc    <= crc_fin;
            err_hlen     <= err_hlen_acc | hlen_bad;
            err_vlen     <= vlen_bad;
            frame_ok     <= ~(err_hlen_acc | hlen_bad | vlen_bad | crc_bad);
            frame_cnt    <= frame_cnt + 16'd1;
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
            crc_mismatch <= crc_bad;
`endif
            pix_cnt      <= '0;
            line_cnt     <= '0;
            crc          <= CRC_INIT;
            err_hlen_acc <= 1'b0;
          end else begin
            de_q <= vid.de;
            if (vid.de) begin
              pix_cnt <= pix_fin;
              crc     <= crc_step;
            end
            if (line_end) begin
              line_cnt     <= line_fin;
              err_hlen_acc <= err_hlen_acc | hlen_bad;
              pix_cnt      <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_frame_checker.sv
// Directed bench for vid_frame_checker on a reduced 16x10 raster; covers VID_FRAME_CHECKER_CRC_CMP_EN when defined.
module tb_vid_frame_checker;

  localparam int H = 16;
  localparam int V = 10;

  logic        clk_pix = 1'b0;
  logic        resetn  = 1'b0;
  logic        frame_done;
  logic [15:0] frame_crc;
  logic        frame_ok;
  logic        err_hlen;
  logic        err_vlen;
  logic [15:0] frame_cnt;
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
  logic [15:0] exp_crc = 16'h0000;
  logic        crc_mismatch;
`endif

  vid_frame_checker_if vid ();

  vid_frame_checker #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .CRC_INIT (16'hFFFF)
  ) dut (
    .clk_pix      (clk_pix),
    .resetn       (resetn),
    .vid          (vid),
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
    .exp_crc      (exp_crc),
    .crc_mismatch (crc_mismatch),
`endif
    .frame_done   (frame_done),
    .frame_crc    (frame_crc),
    .frame_ok     (frame_ok),
    .err_hlen     (err_hlen),
    .err_vlen     (err_vlen),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          done_cnt     = 0;
  logic [15:0] model_crc    = 16'hFFFF;
  logic [15:0] snap_crc     = 16'h0000;
  logic [15:0] ref_crc      = 16'h0000;
  logic [15:0] exp_cnt      = 16'h0000;

  always @(negedge clk_pix) if (frame_done === 1'b1) done_cnt++;

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [8:0] s);
    logic [15:0] r;
    r = c;
    for (int k = 8; k >= 0; k--) begin
      if (r[15] != s[k]) r = (r << 1) ^ 16'h1021;
      else               r = (r << 1);
    end
    return r;
  endfunction

  function automatic logic [8:0] pat(input int kind, input int x, input int y);
    case (kind)
      1:       return (((x + y) % 2) == 0) ? 9'h1FF : 9'h000;
      2:       return 9'((x * 7 + y * 13 + 5) % 512);
      default: return 9'h000;
    endcase
  endfunction

  task automatic cyc(input logic d, input logic vs, input logic [8:0] s);
    vid.de   = d;
    vid.vs_n = vs;
    {vid.rgb_r, vid.rgb_g, vid.rgb_b} = s;
    if (d) model_crc = crc_ref(model_crc, s);
    @(posedge clk_pix);
    #1;
  endtask

  task automatic vsync_only();
    repeat (3) cyc(1'b0, 1'b0, 9'h000);
    model_crc = 16'hFFFF;
    repeat (3) cyc(1'b0, 1'b1, 9'h000);
  endtask

  task automatic send_frame(input int kind, input int nlines, input int short_y,
                            input bit flip, input bit coinc, input int crc_off);
    int          len;
    logic [8:0]  s;
    bit          last;
    for (int y = 0; y < nlines; y++) begin
      len = (y == short_y) ? H - 1 : H;
      for (int x = 0; x < len; x++) begin
        s    = pat(kind, x, y);
        last = coinc && (y == nlines - 1) && (x == len - 1);
        if (flip && x == 5 && y == 7) s = s ^ 9'h001;
        if (last) begin
          snap_crc = crc_ref(model_crc, s);
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
          exp_crc = snap_crc + 16'(crc_off);
`endif
        end
        cyc(1'b1, last ? 1'b0 : 1'b1, s);
      end
      if (!(coinc && y == nlines - 1)) repeat (4) cyc(1'b0, 1'b1, 9'h000);
    end
    if (!coinc) begin
      snap_crc = model_crc;
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
      exp_crc = snap_crc + 16'(crc_off);
`endif
      cyc(1'b0, 1'b0, 9'h000);
    end
    repeat (2) cyc(1'b0, 1'b0, 9'h000);
    model_crc = 16'hFFFF;
    repeat (3) cyc(1'b0, 1'b1, 9'h000);
  endtask

  task automatic test_reset();
    vid.de = 1'b0; vid.vs_n = 1'b1;
    {vid.rgb_r, vid.rgb_g, vid.rgb_b} = 9'h000;
    resetn = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b want 0", frame_done); end
    tests_run++; if (frame_crc !== 16'h0000) begin tests_failed++; $display("FAIL rst_crc: got %h want 0000", frame_crc); end
    tests_run++; if (frame_ok !== 1'b0) begin tests_failed++; $display("FAIL rst_ok: got %b want 0", frame_ok); end
    tests_run++; if (err_hlen !== 1'b0) begin tests_failed++; $display("FAIL rst_hlen: got %b want 0", err_hlen); end
    tests_run++; if (err_vlen !== 1'b0) begin tests_failed++; $display("FAIL rst_vlen: got %b want 0", err_vlen); end
    tests_run++; if (frame_cnt !== 16'h0000) begin tests_failed++; $display("FAIL rst_cnt: got %h want 0000", frame_cnt); end
    resetn = 1'b1;
    cyc(1'b0, 1'b1, 9'h000);
  endtask

  task automatic test_black_frames();
    int d0;
    vsync_only();
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL first_vsync_no_done: got %0d want 0", done_cnt); end
    ref_crc = 16'hFFFF;
    for (int i = 0; i < H * V; i++) ref_crc = crc_ref(ref_crc, 9'h000);
    for (int f = 0; f < 2; f++) begin
      d0 = done_cnt;
      send_frame(0, V, -1, 1'b0, 1'b0, 0);
      exp_cnt++;
      tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL black_done_pulse: got %0d pulses want 1", done_cnt - d0); end
      tests_run++; if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL black_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
      tests_run++; if (frame_ok !== 1'b1) begin tests_failed++; $display("FAIL black_ok: got %b want 1", frame_ok); end
      tests_run++; if (err_hlen !== 1'b0) begin tests_failed++; $display("FAIL black_hlen: got %b want 0", err_hlen); end
      tests_run++; if (err_vlen !== 1'b0) begin tests_failed++; $display("FAIL black_vlen: got %b want 0", err_vlen); end
      tests_run++; if (frame_crc !== ref_crc) begin tests_failed++; $display("FAIL black_crc: got %h want %h", frame_crc, ref_crc); end
    end
  endtask

  task automatic test_hlen();
    send_frame(0, V, 2, 1'b0, 1'b0, 0);
    exp_cnt++;
    tests_run++; if (err_hlen !== 1'b1) begin tests_failed++; $display("FAIL short_hlen: got %b want 1", err_hlen); end
    tests_run++; if (err_vlen !== 1'b0) begin tests_failed++; $display("FAIL short_vlen: got %b want 0", err_vlen); end
    tests_run++; if (frame_ok !== 1'b0) begin tests_failed++; $display("FAIL short_ok: got %b want 0", frame_ok); end
    tests_run++; if (frame_crc !== snap_crc) begin tests_failed++; $display("FAIL short_crc: got %h want %h", frame_crc, snap_crc); end
    send_frame(0, V, -1, 1'b0, 1'b0, 0);
    exp_cnt++;
    tests_run++; if (err_hlen !== 1'b0) begin tests_failed++; $display("FAIL recover_hlen: got %b want 0", err_hlen); end
    tests_run++; if (frame_ok !== 1'b1) begin tests_failed++; $display("FAIL recover_ok: got %b want 1", frame_ok); end
  endtask

  task automatic test_vlen();
    send_frame(0, V - 1, -1, 1'b0, 1'b0, 0);
    exp_cnt++;
    tests_run++; if (err_vlen !== 1'b1) begin tests_failed++; $display("FAIL lines_minus_vlen: got %b want 1", err_vlen); end
    tests_run++; if (err_hlen !== 1'b0) begin tests_failed++; $display("FAIL lines_minus_hlen: got %b want 0", err_hlen); end
    tests_run++; if (frame_ok !== 1'b0) begin tests_failed++; $display("FAIL lines_minus_ok: got %b want 0", frame_ok); end
    send_frame(0, V + 1, -1, 1'b0, 1'b0, 0);
    exp_cnt++;
    tests_run++; if (err_vlen !== 1'b1) begin tests_failed++; $display("FAIL lines_plus_vlen: got %b want 1", err_vlen); end
    tests_run++; if (frame_ok !== 1'b0) begin tests_failed++; $display("FAIL lines_plus_ok: got %b want 0", frame_ok); end
    tests_run++; if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL lines_plus_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_crc_pattern();
    logic [15:0] first;
    send_frame(1, V, -1, 1'b0, 1'b0, 0);
    exp_cnt++;
    first = frame_crc;
    tests_run++; if (first !== snap_crc) begin tests_failed++; $display("FAIL checker_crc: got %h want %h", first, snap_crc); end
    send_frame(1, V, -1, 1'b0, 1'b0, 0);
    exp_cnt++;
    tests_run++; if (frame_crc !== first) begin tests_failed++; $display("FAIL checker_repeat: got %h want %h", frame_crc, first); end
    send_frame(1, V, -1, 1'b1, 1'b0, 0);
    exp_cnt++;
    tests_run++; if (frame_crc === first) begin tests_failed++; $display("FAIL flip_differs: got %h want not %h", frame_crc, first); end
    tests_run++; if (frame_crc !== snap_crc) begin tests_failed++; $display("FAIL flip_crc: got %h want %h", frame_crc, snap_crc); end
  endtask

  task automatic test_coincident();
    int d0;
    d0 = done_cnt;
    send_frame(2, V, -1, 1'b0, 1'b1, 0);
    exp_cnt++;
    tests_run++; if (done_cnt - d0 !== 1) begin tests_failed++; $display("FAIL coinc_done: got %0d pulses want 1", done_cnt - d0); end
    tests_run++; if (frame_crc !== snap_crc) begin tests_failed++; $display("FAIL coinc_crc: got %h want %h", frame_crc, snap_crc); end
    tests_run++; if (err_vlen !== 1'b0) begin tests_failed++; $display("FAIL coinc_vlen: got %b want 0", err_vlen); end
    tests_run++; if (err_hlen !== 1'b0) begin tests_failed++; $display("FAIL coinc_hlen: got %b want 0", err_hlen); end
    tests_run++; if (frame_ok !== 1'b1) begin tests_failed++; $display("FAIL coinc_ok: got %b want 1", frame_ok); end
  endtask

  task automatic test_reset_mid();
    int d0;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < H; x++) cyc(1'b1, 1'b1, pat(2, x, y));
      repeat (4) cyc(1'b0, 1'b1, 9'h000);
    end
    for (int x = 0; x < 6; x++) cyc(1'b1, 1'b1, pat(2, x, 3));
    vid.de = 1'b0;
    resetn = 1'b0;
    #1;
    tests_run++; if (frame_cnt !== 16'h0000) begin tests_failed++; $display("FAIL midrst_cnt: got %h want 0000", frame_cnt); end
    tests_run++; if (frame_crc !== 16'h0000) begin tests_failed++; $display("FAIL midrst_crc: got %h want 0000", frame_crc); end
    tests_run++; if (frame_ok !== 1'b0) begin tests_failed++; $display("FAIL midrst_ok: got %b want 0", frame_ok); end
    repeat (3) cyc(1'b0, 1'b1, 9'h000);
    resetn = 1'b1;
    for (int y = 4; y < V; y++) begin
      for (int x = 0; x < H; x++) cyc(1'b1, 1'b1, pat(2, x, y));
      repeat (4) cyc(1'b0, 1'b1, 9'h000);
    end
    d0 = done_cnt;
    vsync_only();
    tests_run++; if (done_cnt !== d0) begin tests_failed++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
    send_frame(0, V, -1, 1'b0, 1'b0, 0);
    exp_cnt = 16'd1;
    tests_run++; if (frame_cnt !== exp_cnt) begin tests_failed++; $display("FAIL midrst_cnt_after: got %0d want 1", frame_cnt); end
    tests_run++; if (frame_ok !== 1'b1) begin tests_failed++; $display("FAIL midrst_ok_after: got %b want 1", frame_ok); end
  endtask

`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
  task automatic test_crc_cmp();
    send_frame(2, V, -1, 1'b0, 1'b0, 1);
    exp_cnt++;
    tests_run++; if (crc_mismatch !== 1'b1) begin tests_failed++; $display("FAIL cmp_mismatch: got %b want 1", crc_mismatch); end
    tests_run++; if (frame_ok !== 1'b0) begin tests_failed++; $display("FAIL cmp_ok: got %b want 0", frame_ok); end
    send_frame(2, V, -1, 1'b0, 1'b0, 0);
    exp_cnt++;
    tests_run++; if (crc_mismatch !== 1'b0) begin tests_failed++; $display("FAIL cmp_match: got %b want 0", crc_mismatch); end
    tests_run++; if (frame_ok !== 1'b1) begin tests_failed++; $display("FAIL cmp_ok_match: got %b want 1", frame_ok); end
  endtask
`endif

  initial begin
    test_reset();
    test_black_frames();
    test_hlen();
    test_vlen();
    test_crc_pattern();
    test_coincident();
`ifdef VID_FRAME_CHECKER_CRC_CMP_EN
    test_crc_cmp();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
